// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decoded ID fields, flush, forwarding sources, and the
// EX-side ALU/memory controls plus hazard status returned to the front end.
interface id_ex_if;
  // ID-side decoded instruction
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_alu_f;
  logic        id_alu_src;
  logic        id_reg_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;

  logic        flush;

  // Forwarding sources from later stages
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;

  // EX-side results
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_f;
  logic [4:0]  alu_shamt;
  logic        ex_valid;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [31:0] ex_store_data;
  logic        stall;
  logic [15:0] bubble_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_shamt, id_alu_f, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  alu_a, alu_b, alu_f, alu_shamt, ex_valid, ex_dest, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_shamt, id_alu_f, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output alu_a, alu_b, alu_f, alu_shamt, ex_valid, ex_dest, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and EX-stage operand forwarding from EX/MEM and MEM/WB.
module id_ex_stage (
    input  logic     clk,
    input  logic     rst_n,
    id_ex_if.slave   bus
);

    // Handshake: id_valid marks a real instruction in ID; there is no ready.
    // stall=1 means ID must hold (PC and IF/ID frozen externally) while a
    // bubble enters EX; the held instruction is captured on the next edge.

    logic        ex_valid_q;
    logic [4:0]  ex_rs_q;
    logic [4:0]  ex_rt_q;
    logic [4:0]  ex_dest_q;
    logic [31:0] ex_rs_data_q;
    logic [31:0] ex_rt_data_q;
    logic [31:0] ex_imm_q;
    logic [4:0]  ex_shamt_q;
    logic [3:0]  ex_alu_f_q;
    logic        ex_alu_src_q;
    logic        ex_reg_write_q;
    logic        ex_mem_read_q;
    logic        ex_mem_write_q;
    logic [15:0] bubble_cnt_q;

    logic        uses_rt;
    logic        stall_c;
    logic        bubble;
    logic        count_bubble;
    logic [4:0]  id_dest;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    always_comb begin
        uses_rt      = ~bus.id_alu_src | bus.id_mem_write;
        stall_c      = ~bus.flush & bus.id_valid & ex_valid_q & ex_mem_read_q &
                       (ex_dest_q != 5'd0) &
                       ((ex_dest_q == bus.id_rs) | (uses_rt & (ex_dest_q == bus.id_rt)));
        bubble       = bus.flush | stall_c | ~bus.id_valid;
        count_bubble = bus.flush | stall_c;
        id_dest      = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_rs_q        <= 5'd0;
            ex_rt_q        <= 5'd0;
            ex_dest_q      <= 5'd0;
            ex_rs_data_q   <= 32'd0;
            ex_rt_data_q   <= 32'd0;
            ex_imm_q       <= 32'd0;
            ex_shamt_q     <= 5'd0;
            ex_alu_f_q     <= 4'd0;
            ex_alu_src_q   <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
        end else if (bubble) begin
            ex_valid_q     <= 1'b0;
            ex_rs_q        <= 5'd0;
            ex_rt_q        <= 5'd0;
            ex_dest_q      <= 5'd0;
            ex_rs_data_q   <= 32'd0;
            ex_rt_data_q   <= 32'd0;
            ex_imm_q       <= 32'd0;
            ex_shamt_q     <= 5'd0;
            ex_alu_f_q     <= 4'd0;
            ex_alu_src_q   <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
        end else begin
            ex_valid_q     <= 1'b1;
            ex_rs_q        <= bus.id_rs;
            ex_rt_q        <= bus.id_rt;
            ex_dest_q      <= id_dest;
            ex_rs_data_q   <= bus.id_rs_data;
            ex_rt_data_q   <= bus.id_rt_data;
            ex_imm_q       <= bus.id_imm;
            ex_shamt_q     <= bus.id_shamt;
            ex_alu_f_q     <= bus.id_alu_f;
            ex_alu_src_q   <= bus.id_alu_src;
            // Writes to r0 are dropped here so later forwarding never sees them.
            ex_reg_write_q <= bus.id_reg_write & (id_dest != 5'd0);
            ex_mem_read_q  <= bus.id_mem_read;
            ex_mem_write_q <= bus.id_mem_write;
        end
    end

    // Counts only hazard/flush bubbles, not idle slots from id_valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 16'd0;
        end else if (count_bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    // Forwarding: EX/MEM is younger than MEM/WB, so it wins; r0 never forwards.
    always_comb begin
        fwd_rs = ex_rs_data_q;
        if (bus.exmem_reg_write && (bus.exmem_rd == ex_rs_q) && (ex_rs_q != 5'd0))
            fwd_rs = bus.exmem_result;
        else if (bus.memwb_reg_write && (bus.memwb_rd == ex_rs_q) && (ex_rs_q != 5'd0))
            fwd_rs = bus.memwb_result;

        fwd_rt = ex_rt_data_q;
        if (bus.exmem_reg_write && (bus.exmem_rd == ex_rt_q) && (ex_rt_q != 5'd0))
            fwd_rt = bus.exmem_result;
        else if (bus.memwb_reg_write && (bus.memwb_rd == ex_rt_q) && (ex_rt_q != 5'd0))
            fwd_rt = bus.memwb_result;
    end

    assign bus.alu_a         = ex_valid_q ? fwd_rs : 32'd0;
    assign bus.alu_b         = ex_valid_q ? (ex_alu_src_q ? ex_imm_q : fwd_rt) : 32'd0;
    assign bus.ex_store_data = ex_valid_q ? fwd_rt : 32'd0;
    assign bus.alu_f         = ex_alu_f_q;
    assign bus.alu_shamt     = ex_shamt_q;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_dest       = ex_dest_q;
    assign bus.ex_reg_write  = ex_reg_write_q;
    assign bus.ex_mem_read   = ex_mem_read_q;
    assign bus.ex_mem_write  = ex_mem_write_q;
    assign bus.stall         = stall_c;
    assign bus.bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, forwarding priority, load-use
// stalls, flush, immediate/store operands, async reset and counter saturation.
module tb_id_ex_stage;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_ex_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rs_d,
                          input logic [31:0] rt_d, input logic [31:0] imm,
                          input logic [4:0] sh, input logic [3:0] f, input logic asrc,
                          input logic rdst, input logic rw, input logic mr, input logic mw);
    bus.id_valid     = v;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_rs_data   = rs_d;
    bus.id_rt_data   = rt_d;
    bus.id_imm       = imm;
    bus.id_shamt     = sh;
    bus.id_alu_f     = f;
    bus.id_alu_src   = asrc;
    bus.id_reg_dst   = rdst;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
  endtask

  task automatic drive_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exmem_reg_write = ew;
    bus.exmem_rd        = erd;
    bus.exmem_result    = eres;
    bus.memwb_reg_write = mw;
    bus.memwb_rd        = mrd;
    bus.memwb_result    = mres;
  endtask

  task automatic idle();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lw r5, 0(r1) into ID
  task automatic drive_lw_r5();
    drive_id(1'b1, 5'd1, 5'd5, 5'd0, 32'h100, 32'd0, 32'd0, 5'd0, 4'd0,
             1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  // add r6 = r5 + r1 into ID
  task automatic drive_add_r6();
    drive_id(1'b1, 5'd5, 5'd1, 5'd6, 32'h50, 32'h10, 32'd0, 5'd0, 4'd0,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    idle();
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    checks++;
    if (bus.ex_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ex_valid got %b exp 0", bus.ex_valid);
    end
    checks++;
    if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.ex_store_data !== 32'd0) begin
      errors++; $display("FAIL reset_operands got a=%h b=%h sd=%h exp 0", bus.alu_a, bus.alu_b, bus.ex_store_data);
    end
    checks++;
    if (bus.bubble_cnt !== 16'd0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_stall got cnt=%h stall=%b exp 0/0", bus.bubble_cnt, bus.stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    @(negedge clk);
    // add r3 = r1 + r2
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 5'd0, 4'd0,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin
      errors++; $display("FAIL capture_operands got a=%h b=%h exp 5/7", bus.alu_a, bus.alu_b);
    end
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd3 || bus.ex_reg_write !== 1'b1 || bus.alu_f !== 4'd0) begin
      errors++; $display("FAIL capture_ctrl got v=%b d=%0d rw=%b f=%h exp 1/3/1/0",
                         bus.ex_valid, bus.ex_dest, bus.ex_reg_write, bus.alu_f);
    end
    @(negedge clk);
    // sll-like: alu_f/shamt pass through; dest = rt = 0 drops reg_write
    drive_id(1'b1, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 5'd17, 4'hA,
             1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.alu_f !== 4'hA || bus.alu_shamt !== 5'd17) begin
      errors++; $display("FAIL capture_f_shamt got f=%h sh=%0d exp a/17", bus.alu_f, bus.alu_shamt);
    end
    checks++;
    if (bus.ex_dest !== 5'd0 || bus.ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL dest_r0 got d=%0d rw=%b exp 0/0", bus.ex_dest, bus.ex_reg_write);
    end
    @(negedge clk);
    idle();
    step();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.alu_shamt !== 5'd0 || bus.bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL idle_bubble got v=%b sh=%0d cnt=%h exp 0/0/0",
                         bus.ex_valid, bus.alu_shamt, bus.bubble_cnt);
    end
  endtask

  task automatic test_forward();
    @(negedge clk);
    drive_id(1'b1, 5'd4, 5'd8, 5'd9, 32'h99, 32'h88, 32'd0, 5'd0, 4'd0,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive_fwd(1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
    #1;
    checks++;
    if (bus.alu_a !== 32'h11) begin
      errors++; $display("FAIL fwd_exmem_prio got %h exp 00000011", bus.alu_a);
    end
    bus.exmem_reg_write = 1'b0;
    #1;
    checks++;
    if (bus.alu_a !== 32'h22) begin
      errors++; $display("FAIL fwd_memwb got %h exp 00000022", bus.alu_a);
    end
    checks++;
    if (bus.alu_b !== 32'h88) begin
      errors++; $display("FAIL fwd_rt_nomatch got %h exp 00000088", bus.alu_b);
    end
    @(negedge clk);
    drive_id(1'b1, 5'd0, 5'd8, 5'd9, 32'h55, 32'h66, 32'd0, 5'd0, 4'd0,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
    step();
    checks++;
    if (bus.alu_a !== 32'h55) begin
      errors++; $display("FAIL fwd_r0 got %h exp 00000055", bus.alu_a);
    end
    @(negedge clk);
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle();
    step();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive_lw_r5();
    step();
    @(negedge clk);
    drive_add_r6();
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("FAIL load_use_stall got %b exp 1", bus.stall);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.bubble_cnt !== 16'd1 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL load_use_bubble got v=%b cnt=%h stall=%b exp 0/1/0",
                         bus.ex_valid, bus.bubble_cnt, bus.stall);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd6 || bus.alu_a !== 32'h50) begin
      errors++; $display("FAIL load_use_capture got v=%b d=%0d a=%h exp 1/6/50",
                         bus.ex_valid, bus.ex_dest, bus.alu_a);
    end
    // lw r5 then an immediate op reading r5 only through rt: no hazard
    @(negedge clk);
    drive_lw_r5();
    step();
    @(negedge clk);
    drive_id(1'b1, 5'd1, 5'd5, 5'd0, 32'h1, 32'h2, 32'h4, 5'd0, 4'd0,
             1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL no_stall_imm_rt got %b exp 0", bus.stall);
    end
    step();
    // same pair but the consumer is a store, so rt matters
    @(negedge clk);
    drive_lw_r5();
    step();
    @(negedge clk);
    drive_id(1'b1, 5'd1, 5'd5, 5'd0, 32'h1, 32'h2, 32'h4, 5'd0, 4'd0,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("FAIL stall_store_rt got %b exp 1", bus.stall);
    end
    step();
    checks++;
    if (bus.bubble_cnt !== 16'd2) begin
      errors++; $display("FAIL store_bubble_cnt got %h exp 0002", bus.bubble_cnt);
    end
    @(negedge clk);
    idle();
    step();
  endtask

  task automatic test_flush_stall();
    @(negedge clk);
    drive_lw_r5();
    step();
    @(negedge clk);
    drive_add_r6();
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL flush_masks_stall got %b exp 0", bus.stall);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.bubble_cnt !== 16'd3) begin
      errors++; $display("FAIL flush_bubble got v=%b cnt=%h exp 0/0003", bus.ex_valid, bus.bubble_cnt);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    step();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd6 || bus.bubble_cnt !== 16'd3) begin
      errors++; $display("FAIL after_flush_capture got v=%b d=%0d cnt=%h exp 1/6/0003",
                         bus.ex_valid, bus.ex_dest, bus.bubble_cnt);
    end
    @(negedge clk);
    idle();
    step();
  endtask

  task automatic test_imm_store();
    @(negedge clk);
    // sw r7, -4(r2)
    drive_id(1'b1, 5'd2, 5'd7, 5'd0, 32'h200, 32'h1234, 32'hFFFFFFFC, 5'd0, 4'd0,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD);
    step();
    checks++;
    if (bus.alu_b !== 32'hFFFFFFFC || bus.ex_store_data !== 32'hDEAD) begin
      errors++; $display("FAIL imm_store got b=%h sd=%h exp fffffffc/0000dead", bus.alu_b, bus.ex_store_data);
    end
    checks++;
    if (bus.ex_mem_write !== 1'b1 || bus.ex_reg_write !== 1'b0 || bus.alu_a !== 32'h200) begin
      errors++; $display("FAIL store_ctrl got mw=%b rw=%b a=%h exp 1/0/200",
                         bus.ex_mem_write, bus.ex_reg_write, bus.alu_a);
    end
    @(negedge clk);
    idle();
    step();
    checks++;
    if (bus.ex_store_data !== 32'd0 || bus.alu_b !== 32'd0) begin
      errors++; $display("FAIL invalid_zero_ops got sd=%h b=%h exp 0/0", bus.ex_store_data, bus.alu_b);
    end
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h77, 32'h1, 32'd0, 5'd0, 4'd0,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.alu_a !== 32'd0 || bus.bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL async_reset got v=%b a=%h cnt=%h exp 0/0/0",
                         bus.ex_valid, bus.alu_a, bus.bubble_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_lw_r5();
    step();
    @(negedge clk);
    drive_add_r6();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.ex_mem_read !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stall got stall=%b mr=%b exp 0/0", bus.stall, bus.ex_mem_read);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.bubble_cnt !== 16'd0 || bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd6) begin
      errors++; $display("FAIL post_reset_capture got cnt=%h v=%b d=%0d exp 0/1/6",
                         bus.bubble_cnt, bus.ex_valid, bus.ex_dest);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_saturation();
    @(negedge clk);
    bus.flush = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    checks++;
    if (bus.bubble_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach got %h exp ffff", bus.bubble_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.bubble_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold got %h exp ffff", bus.bubble_cnt);
    end
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_capture();
    test_forward();
    test_load_use();
    test_flush_stall();
    test_imm_store();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
